// File: rtl/fetch_pkg.sv
// Shared defaults and the buffer-entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH  = 7;
  localparam int unsigned FETCH_INSTR_WIDTH = 32;
  localparam int unsigned FETCH_RESET_PC    = 0;
  localparam int unsigned FETCH_BUF_DEPTH   = 2;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instruction;
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port and decode-side valid/ready handshake of the fetch stage.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH
);
  logic                   imem_en;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [ADDR_WIDTH-1:0]  out_pc_next;

  modport master (
    output imem_en, imem_addr, out_valid, out_instruction, out_pc, out_pc_next,
    input  imem_data, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_instruction, out_pc, out_pc_next,
    output imem_data, out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// First-word fall-through FIFO: an entry pushed into an empty buffer is visible at the head the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = FETCH_BUF_DEPTH,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output entry_t           head_data,
  output logic [CNT_W-1:0] occupancy
);
  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s;
  logic             write_s;
  logic             read_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // head selection; a push popped straight through an empty buffer never gets stored
  always_comb begin
    empty_s    = (count_r == '0);
    head_valid = !empty_s || push;
    head_data  = empty_s ? push_data : mem_r[rd_ptr_r];
    write_s    = push && !(empty_s && pop);
    read_s     = pop && !empty_s;
  end

  // pointers and occupancy, flush dominating push and pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (write_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (read_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(write_s) - CNT_W'(read_s);
    end
  end

  // entry storage
  always_ff @(posedge clock) begin
    if (write_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

  assign occupancy = count_r;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, one-cycle-latency memory reads, epoch-tagged redirect flush.
// Optional perf_fetched/perf_stalls outputs are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int unsigned RESET_PC    = FETCH_RESET_PC,
  parameter int unsigned BUF_DEPTH   = FETCH_BUF_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_if.master               bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stalls
`endif
);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] inflight_pc_r;
  logic                  inflight_r;
  logic                  inflight_epoch_r;
  logic                  epoch_r;
  logic [CNT_W-1:0]      occupancy_s;
  logic                  redirect_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  head_valid_s;
  entry_t                push_entry_s;
  entry_t                head_entry_s;

  // issue only into guaranteed buffer space, so out_ready reaches imem_en only via occupancy
  always_comb begin
    redirect_s   = enable && redirect_valid;
    issue_s      = reset_n && enable && !redirect_valid &&
                   ((SUM_W'(occupancy_s) + SUM_W'(inflight_r)) < SUM_W'(BUF_DEPTH));
    push_s       = inflight_r && (inflight_epoch_r == epoch_r);
    push_entry_s.instruction = bus.imem_data;
    push_entry_s.pc          = inflight_pc_r;
    pop_s        = enable && !redirect_valid && bus.out_ready && head_valid_s;
    bus.imem_en         = issue_s;
    bus.imem_addr       = pc_r;
    bus.out_valid       = head_valid_s;
    bus.out_instruction = head_entry_s.instruction;
    bus.out_pc          = head_entry_s.pc;
    bus.out_pc_next     = head_entry_s.pc + ADDR_WIDTH'(1);
  end

  // program counter and epoch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r    <= ADDR_WIDTH'(RESET_PC);
      epoch_r <= 1'b0;
    end else if (redirect_s) begin
      pc_r    <= redirect_pc;
      epoch_r <= !epoch_r;
    end else if (issue_s) begin
      pc_r    <= pc_r + ADDR_WIDTH'(1);
    end
  end

  // in-flight request tracking; clears itself once the response has been captured
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r       <= 1'b0;
      inflight_pc_r    <= '0;
      inflight_epoch_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r    <= pc_r;
        inflight_epoch_r <= epoch_r;
      end
    end
  end

  fetch_buffer #(
    .entry_t (entry_t),
    .DEPTH   (BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push_s),
    .push_data  (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_s),
    .head_valid (head_valid_s),
    .head_data  (head_entry_s),
    .occupancy  (occupancy_s)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  // accepted-instruction and decode-stall counters, frozen while disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'd0;
      perf_stalls  <= 32'd0;
    end else if (enable) begin
      if (pop_s) perf_fetched <= perf_fetched + 32'd1;
      if (head_valid_s && !bus.out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed timing scenarios plus randomized traffic against a stream model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned AW    = 7;
  localparam int unsigned IW    = 32;
  localparam int unsigned RPC   = 0;
  localparam int unsigned DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stalls;
`endif

  fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (RPC),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h100 + {25'd0, a};
  endfunction

  // synchronous instruction memory, one-cycle read latency
  always @(posedge clock) begin
    if (bus.imem_en) bus.imem_data <= mem_word(bus.imem_addr);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  // reference model: the architectural instruction stream and outstanding-request count
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] fetch_pc;
  int            outstanding;
  int            starve;
  logic          prev_hold;
  logic [AW-1:0] prev_pc;
  logic [IW-1:0] prev_instr;
  logic [31:0]   model_fetched;
  logic [31:0]   model_stalls;

  logic          s_vld;
  logic          s_en;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] s_pc;
  logic [AW-1:0] s_pcn;
  logic [IW-1:0] s_instr;

  task automatic model_reset();
    exp_pc        = AW'(RPC);
    fetch_pc      = AW'(RPC);
    outstanding   = 0;
    starve        = 0;
    prev_hold     = 1'b0;
    model_fetched = 32'd0;
    model_stalls  = 32'd0;
  endtask

  task automatic observe();
    logic          accept;
    logic [AW-1:0] nxt;
    s_vld   = bus.out_valid;
    s_en    = bus.imem_en;
    s_addr  = bus.imem_addr;
    s_pc    = bus.out_pc;
    s_pcn   = bus.out_pc_next;
    s_instr = bus.out_instruction;
    if (prev_hold) begin
      check_eq("hold_valid", s_vld, 1'b1);
      check_eq("hold_pc", s_pc, prev_pc);
      check_eq("hold_instr", s_instr, prev_instr);
    end
    check_eq("imem_en", s_en, enable && !redirect_valid && (outstanding < DEPTH));
    if (s_en) check_eq("imem_addr", s_addr, fetch_pc);
    accept = s_vld && bus.out_ready && enable && !redirect_valid;
    if (accept) begin
      nxt = exp_pc + 7'd1;
      check_eq("out_pc", s_pc, exp_pc);
      check_eq("out_instr", s_instr, mem_word(exp_pc));
      check_eq("out_pc_next", s_pcn, nxt);
      exp_pc = nxt;
      outstanding--;
      model_fetched = model_fetched + 32'd1;
    end
    if (enable && s_vld && !bus.out_ready) model_stalls = model_stalls + 32'd1;
    if (enable && redirect_valid) begin
      exp_pc      = redirect_pc;
      fetch_pc    = redirect_pc;
      outstanding = 0;
    end else if (s_en) begin
      fetch_pc = fetch_pc + 7'd1;
      outstanding++;
    end
    if (enable && !redirect_valid && bus.out_ready && !s_vld) begin
      starve++;
      check_eq("starve", starve > 2, 1'b0);
    end else begin
      starve = 0;
    end
    prev_hold  = s_vld && !accept && !(enable && redirect_valid);
    prev_pc    = s_pc;
    prev_instr = s_instr;
  endtask

  task automatic tick();
    #1;
    observe();
    @(negedge clock);
  endtask

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 7'd0;
    bus.out_ready  = 1'b1;
    model_reset();
    @(negedge clock);
    #1;
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_imem_en", bus.imem_en, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // first fetch and streaming
    tick();
    check_eq("first_en", s_en, 1'b1);
    check_eq("first_valid_lo", s_vld, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stream_valid", s_vld, 1'b1);
      check_eq("stream_pc", s_pc, k);
    end

    // decode backpressure
    bus.out_ready = 1'b0;
    repeat (5) tick();
    check_eq("bp_en", s_en, 1'b0);
    check_eq("bp_pc", s_pc, 7'd3);
    bus.out_ready = 1'b1;
    tick();
    check_eq("release_pc3", s_pc, 7'd3);
    tick();
    check_eq("release_pc4", s_pc, 7'd4);

    // redirect with pc 5 buffered and pc 6 in flight
    bus.out_ready = 1'b0;
    tick();
    check_eq("pre_redir_pc", s_pc, 7'd5);
    check_eq("pre_redir_issue", s_addr, 7'd6);
    redirect_valid = 1'b1;
    redirect_pc    = 7'h40;
    tick();
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    check_eq("redir_gap_valid", s_vld, 1'b0);
    check_eq("redir_req_addr", s_addr, 7'h40);
    tick();
    check_eq("redir_tgt_valid", s_vld, 1'b1);
    check_eq("redir_tgt_pc", s_pc, 7'h40);

    // redirect coinciding with an accept
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 7'h20;
    tick();
    check_eq("coinc_valid", s_vld, 1'b1);
    redirect_valid = 1'b0;
    tick();
    check_eq("coinc_gap", s_vld, 1'b0);
    tick();
    check_eq("coinc_tgt_pc", s_pc, 7'h20);

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 7'h7E;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check_eq("wrap_pc0", s_pc, 7'h7E);
    tick();
    check_eq("wrap_pc1", s_pc, 7'h7F);
    check_eq("wrap_pcn", s_pcn, 7'h00);
    tick();
    check_eq("wrap_pc2", s_pc, 7'h00);
    tick();
    check_eq("wrap_pc3", s_pc, 7'h01);

    // randomized enable / backpressure / redirect traffic
    for (int i = 0; i < 3000; i++) begin
      enable         = ($urandom_range(0, 7) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = AW'($urandom_range(0, 127));
      tick();
    end
    enable         = 1'b1;
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (4) tick();
`ifdef FETCH_PERF_COUNTERS_EN
    check_eq("perf_fetched", perf_fetched, model_fetched);
    check_eq("perf_stalls", perf_stalls, model_stalls);
`endif

    // asynchronous reset mid-stream
    check_eq("pre_reset_valid", s_vld, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", bus.out_valid, 1'b0);
    check_eq("midrst_imem_en", bus.imem_en, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check_eq("midrst_perf_fetched", perf_fetched, 32'd0);
    check_eq("midrst_perf_stalls", perf_stalls, 32'd0);
`endif
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_eq("restart_en", s_en, 1'b1);
    check_eq("restart_addr", s_addr, AW'(RPC));
    tick();
    check_eq("restart_valid", s_vld, 1'b1);
    check_eq("restart_pc", s_pc, AW'(RPC));
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
